sc_stream_decoder: RTL and testbench

- Receive end of the stochastic-computing datapath: converts a stochastic bitstream back to a binary value by counting ones over one frame of 2^N valid bits.
- The frame length matches the 2^N-cycle period of the VDC-driven stochastic number generators.
- Supports unipolar (P = ones/2^N) and bipolar (value = 2·ones − 2^N) decoding.
- Result is offered on a valid/ready output port.

---
 rtl/sc_stream_decoder.sv | 86 ++++++++
 tb/tb_sc_stream_decoder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sc_stream_decoder.sv
// Stochastic bitstream decoder: counts ones over a frame of 2^N valid bits and
// presents the unipolar or bipolar value on a valid/ready result port.
module sc_stream_decoder #(
    parameter int N = 12,
    parameter int W = N + 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic         bipolar,
    input  logic         bit_in,
    input  logic         bit_valid,
    output logic [W-1:0] out_value,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy,
    output logic         overrun
);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t       state, state_next;
    logic [N-1:0] cnt;
    logic [N:0]   ones;
    logic [N:0]   ones_next;
    logic         mode;
    logic         accept_start;
    logic         count_en;
    logic         last;
    logic [W-1:0] ones_w;
    logic [W-1:0] result;

    assign accept_start = (state == IDLE) && start;
    assign count_en     = (state == ACCUM) && bit_valid;
    assign last         = count_en && (cnt == {N{1'b1}});
    assign ones_next    = ones + {{N{1'b0}}, bit_in};
    assign ones_w       = {{(W-N-1){1'b0}}, ones_next};
    // Bipolar: 2*ones - 2^N, wrapped into W-bit two's complement.
    assign result       = mode ? ((ones_w << 1) - (W'(1) << N)) : ones_w;
    assign busy         = (state == ACCUM);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ACCUM;
            ACCUM:   if (last)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            ones      <= '0;
            mode      <= 1'b0;
            out_value <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept_start) begin
                cnt     <= '0;
                ones    <= '0;
                mode    <= bipolar;
                overrun <= 1'b0;
            end else if (count_en) begin
                cnt  <= cnt + {{(N-1){1'b0}}, 1'b1};
                ones <= ones_next;
            end
            // A completed frame may replace a result being consumed this cycle;
            // otherwise an unconsumed result wins and the new one is dropped.
            if (last) begin
                if (!out_valid || out_ready) begin
                    out_value <= result;
                    out_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sc_stream_decoder.sv
// Directed bench for sc_stream_decoder with N=4 (16-bit frames, 6-bit result).
module tb_sc_stream_decoder;

    localparam int N = 4;
    localparam int W = 6;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         bipolar = 1'b0;
    logic         bit_in = 1'b0;
    logic         bit_valid = 1'b0;
    logic [W-1:0] out_value;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         busy;
    logic         overrun;

    int n_cmp = 0;
    int n_err = 0;

    sc_stream_decoder #(.N(N), .W(W)) dut (
        .clock(clock), .reset(reset), .start(start), .bipolar(bipolar),
        .bit_in(bit_in), .bit_valid(bit_valid), .out_value(out_value),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
        .overrun(overrun)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic        bp;
        logic [15:0] pat;
        int          gap;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Start cycle carries a valid one that must not be counted.
    task automatic do_start(input logic bp);
        start     = 1'b1;
        bipolar   = bp;
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        tick();
        start     = 1'b0;
        bit_valid = 1'b0;
        bipolar   = 1'b0;
    endtask

    // Sends 16 valid bits (LSB first); gap idle cycles with bit_in=1 precede each.
    // start_at >= 0 asserts start alongside that valid bit.
    task automatic send_frame(input logic [15:0] pat, input int gap, input int start_at);
        for (int i = 0; i < 16; i++) begin
            for (int g = 0; g < gap; g++) begin
                bit_valid = 1'b0;
                bit_in    = 1'b1;
                tick();
            end
            bit_valid = 1'b1;
            bit_in    = pat[i];
            start     = (i == start_at);
            tick();
            start     = 1'b0;
            if (i == 14) check("busy_before_last", busy, 1);
        end
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    initial begin
        vecs[0] = '{"uni_5",      1'b0, 16'h001F, 0, 6'd5};
        vecs[1] = '{"bip_5",      1'b1, 16'h001F, 0, 6'h3A};
        vecs[2] = '{"bip_ones",   1'b1, 16'hFFFF, 0, 6'h10};
        vecs[3] = '{"bip_zeros",  1'b1, 16'h0000, 0, 6'h30};
        vecs[4] = '{"uni_gaps",   1'b0, 16'hFFFF, 2, 6'd16};
        vecs[5] = '{"bip_half",   1'b1, 16'h5A5A, 1, 6'd0};

        tick();
        tick();
        reset = 1'b0;
        check("rst_value",   out_value, 0);
        check("rst_valid",   out_valid, 0);
        check("rst_busy",    busy, 0);
        check("rst_overrun", overrun, 0);

        // Idle valid bits must be ignored.
        bit_valid = 1'b1; bit_in = 1'b1;
        tick(); tick();
        bit_valid = 1'b0;
        check("idle_busy", busy, 0);

        out_ready = 1'b1;
        foreach (vecs[v]) begin
            do_start(vecs[v].bp);
            check({vecs[v].name, "_busy_start"}, busy, 1);
            check({vecs[v].name, "_valid_pre"}, out_valid, 0);
            send_frame(vecs[v].pat, vecs[v].gap, -1);
            check({vecs[v].name, "_valid"}, out_valid, 1);
            check({vecs[v].name, "_value"}, out_value, vecs[v].exp);
            check({vecs[v].name, "_busy_end"}, busy, 0);
            check({vecs[v].name, "_overrun"}, overrun, 0);
            tick();
            check({vecs[v].name, "_popped"}, out_valid, 0);
        end

        // Overrun: consumer stalled across two completions.
        out_ready = 1'b0;
        do_start(1'b0);
        send_frame(16'h007F, 0, -1);
        check("ovr_first_value", out_value, 7);
        check("ovr_first_flag",  overrun, 0);
        do_start(1'b0);
        send_frame(16'h01FF, 0, -1);
        check("ovr_held_value", out_value, 7);
        check("ovr_held_valid", out_valid, 1);
        check("ovr_flag",       overrun, 1);
        tick();
        check("ovr_sticky",     overrun, 1);
        do_start(1'b0);
        check("ovr_cleared",    overrun, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("pop_valid", out_valid, 0);
        check("pop_value", out_value, 7);
        send_frame(16'h0000, 0, -1);
        check("zero_value", out_value, 0);
        check("zero_valid", out_valid, 1);

        // Consumer always ready; start mid-frame must be ignored.
        out_ready = 1'b1;
        do_start(1'b0);
        send_frame(16'h0007, 0, -1);
        check("b2b_first",   out_value, 3);
        check("b2b_valid1",  out_valid, 1);
        do_start(1'b0);
        send_frame(16'h0FFF, 0, 8);
        check("b2b_second",  out_value, 12);
        check("b2b_valid2",  out_valid, 1);
        check("b2b_busy",    busy, 0);
        check("b2b_overrun", overrun, 0);

        // Reset mid-frame with a held result.
        out_ready = 1'b0;
        do_start(1'b0);
        for (int i = 0; i < 8; i++) begin
            bit_valid = 1'b1; bit_in = 1'b1;
            tick();
        end
        bit_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_value", out_value, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_busy",  busy, 0);
        check("mid_rst_ovr",   overrun, 0);
        do_start(1'b0);
        send_frame(16'h03FF, 0, -1);
        check("post_rst_value", out_value, 10);
        check("post_rst_valid", out_valid, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
